// File: rtl/core_pkg.sv
// core_pkg: shared hazard FSM states and pipeline constants
package core_pkg;
  typedef enum logic [1:0] {HZ_RUN, HZ_MWAIT, HZ_HALT} hz_state_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator between EX load and ID sources
module hazard_detect
  import core_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  output logic       load_use
);
  always_comb
    load_use = ex_memread && ex_rd != REG_ZERO && (ex_rd == id_rs1 || ex_rd == id_rs2);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencing with memory wait FSM; HAZARD_PERF_EN adds stall/flush counters
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        br_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_req,
  input  logic        resume,
  output logic        pc_hold,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_bubble,
  output logic        halted,
  output logic        mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  localparam int CW = $clog2(MEM_TIMEOUT) + 1;
  hz_state_e state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic halt_pend_q, halt_pend_d, mem_err_q, mem_err_d;
  logic load_use, freeze, br, lu;
  hazard_detect u_detect (
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread), .load_use(load_use)
  );
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    halt_pend_d = halt_pend_q;
    mem_err_d = mem_err_q;
    freeze = 1'b0;
    br = 1'b0;
    lu = 1'b0;
    unique case (state_q)
      HZ_RUN:
        if (mem_req && !mem_ready) begin
          freeze = 1'b1;
          state_d = HZ_MWAIT;
          wcnt_d = CW'(1);
        end else begin
          br = br_taken;
          lu = !br_taken && load_use;
          if (halt_req && !br_taken && !load_use) begin
            state_d = HZ_HALT;
            halt_pend_d = 1'b0;
          end
        end
      HZ_MWAIT: begin
        halt_pend_d = halt_pend_q || halt_req;
        if (mem_ready) begin
          br = br_taken;
          lu = !br_taken && load_use;
          state_d = halt_pend_q ? HZ_HALT : HZ_RUN;
          halt_pend_d = 1'b0;
        end else begin
          freeze = 1'b1;
          if (wcnt_q >= CW'(MEM_TIMEOUT)) begin
            mem_err_d = 1'b1;
            state_d = HZ_HALT;
            halt_pend_d = 1'b0;
          end else if (wcnt_q != '1) begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      HZ_HALT: begin
        freeze = 1'b1;
        if (resume && !halt_req) begin
          state_d = HZ_RUN;
          halt_pend_d = 1'b0;
          mem_err_d = 1'b0;
        end
      end
      default: state_d = HZ_RUN;
    endcase
  end
  assign pc_hold = freeze || lu;
  assign if_id_stall = freeze || lu;
  assign id_ex_stall = freeze;
  assign ex_mem_stall = freeze;
  assign mem_wb_bubble = freeze;
  assign if_id_flush = br;
  assign id_ex_flush = br || lu;
  assign halted = state_q == HZ_HALT;
  assign mem_err = mem_err_q;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= HZ_RUN;
      wcnt_q <= '0;
      halt_pend_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      halt_pend_q <= halt_pend_d;
      mem_err_q <= mem_err_d;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, pc_hold};
    flush_cnt_d = flush_cnt_q + {31'd0, if_id_flush};
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl with MEM_TIMEOUT=4
module tb_hazard_ctrl;
  logic clk, rstn;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic ex_memread, br_taken, mem_req, mem_ready, halt_req, resume;
  logic pc_hold, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush;
  logic mem_wb_bubble, halted, mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  logic [8:0] outs;
  int n_chk = 0;
  int n_err = 0;
  localparam logic [8:0] ZERO = 9'b0000000_00;
  localparam logic [8:0] LU   = 9'b1100010_00;
  localparam logic [8:0] BR   = 9'b0000110_00;
  localparam logic [8:0] FRZ  = 9'b1111001_00;
  localparam logic [8:0] HLT  = 9'b1111001_10;
  localparam logic [8:0] HLTE = 9'b1111001_11;
  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .halt_req(halt_req), .resume(resume), .pc_hold(pc_hold), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .mem_wb_bubble(mem_wb_bubble), .halted(halted), .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );
  assign outs = {pc_hold, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush,
                 mem_wb_bubble, halted, mem_err};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(string tag, logic [8:0] exp);
    #1;
    check(tag, {23'd0, outs}, {23'd0, exp});
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {id_rs1, id_rs2, ex_rd} = '0;
    {ex_memread, br_taken, mem_req, mem_ready, halt_req, resume} = '0;
  endtask
  initial begin
    rstn = 1'b0;
    idle();
    @(posedge clk);
    #1;
    tick("reset", ZERO);
    rstn = 1'b1;
    ex_rd = 5; id_rs1 = 5; ex_memread = 1;
    tick("lu_rs1", LU);
    ex_memread = 0;
    tick("lu_bubble", ZERO);
    ex_rd = 7; id_rs1 = 1; id_rs2 = 7; ex_memread = 1;
    tick("lu_rs2", LU);
    ex_rd = 0; id_rs1 = 0; id_rs2 = 3;
    tick("lu_x0", ZERO);
    ex_rd = 5; id_rs1 = 5; ex_memread = 0;
    tick("no_load", ZERO);
    ex_memread = 1; br_taken = 1;
    tick("br_over_lu", BR);
    idle();
    mem_req = 1;
    tick("mw_run", FRZ);
    br_taken = 1; ex_memread = 1; ex_rd = 5; id_rs1 = 5;
    tick("mw_ign", FRZ);
    idle(); mem_req = 1;
    tick("mw_2", FRZ);
    mem_ready = 1; br_taken = 1;
    tick("mw_rel_br", BR);
    idle();
    tick("mw_back", ZERO);
    mem_req = 1;
    tick("hp_run", FRZ);
    halt_req = 1;
    tick("hp_wait", FRZ);
    mem_ready = 1;
    tick("hp_rel", ZERO);
    mem_req = 0; mem_ready = 0;
    tick("hp_halt", HLT);
    resume = 1;
    tick("res_held", HLT);
    resume = 0; halt_req = 0;
    tick("res_ign", HLT);
    resume = 1;
    tick("res_cyc", HLT);
    resume = 0;
    tick("res_run", ZERO);
    halt_req = 1; br_taken = 1;
    tick("h_br", BR);
    idle();
    tick("h_br_no", ZERO);
    halt_req = 1;
    tick("h_acc", ZERO);
    halt_req = 0;
    tick("h_halt", HLT);
    resume = 1;
    tick("h_res", HLT);
    resume = 0;
    tick("h_run", ZERO);
    mem_req = 1;
    tick("to_run", FRZ);
    tick("to_w1", FRZ);
    tick("to_w2", FRZ);
    tick("to_w3", FRZ);
    tick("to_w4", FRZ);
    mem_req = 0;
    tick("to_err", HLTE);
    resume = 1;
    tick("to_res", HLTE);
    resume = 0;
    tick("to_clr", ZERO);
    mem_req = 1;
    tick("rm_run", FRZ);
    rstn = 0; mem_req = 0;
    tick("rm_wait", FRZ);
    rstn = 1;
    tick("rm_out", ZERO);
    halt_req = 1;
    tick("rh_acc", ZERO);
    halt_req = 0;
    tick("rh_halt", HLT);
    rstn = 0;
    tick("rh_rst", HLT);
    rstn = 1;
    tick("rh_out", ZERO);
`ifdef HAZARD_PERF_EN
    check("stall_rst", stall_cnt, 32'd0);
    check("flush_rst", flush_cnt, 32'd0);
    ex_rd = 5; id_rs1 = 5; ex_memread = 1;
    tick("pf_lu", LU);
    ex_memread = 0; br_taken = 1;
    tick("pf_br", BR);
    idle();
    check("stall_cnt", stall_cnt, 32'd1);
    check("flush_cnt", flush_cnt, 32'd1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing unit for the 5-stage core. It observes ID/EX register indices, the EX-stage branch resolution, the MEM-stage data-memory handshake and the debug halt request. From these it drives the PC hold (`fstall` of `PC_Controller`) and every stage-register stall, flush and bubble control. It also contains a wait-state FSM with timeout for slow data memory, and optional stall/flush performance counters.

## Interface
- `MEM_TIMEOUT`, default 64: maximum consecutive MWAIT cycles before an error is raised; minimum 2.
- `clk`  in  1  core clock, all state on rising edge
- `rstn`  in  1  reset; synchronous, active-low
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID
- `ex_rd`  in  5  destination register of the instruction in EX
- `ex_memread`  in  1  EX instruction is a load
- `br_taken`  in  1  EX resolved a taken branch/jump this cycle
- `mem_req`  in  1  MEM stage holds a valid load/store
- `mem_ready`  in  1  data memory completes the access this cycle
- `halt_req`  in  1  debug halt request, level
- `resume`  in  1  debug resume, single-cycle pulse
- `pc_hold`  out  1  PC keeps its value (to `PC_Controller.fstall`)
- `if_id_stall`, `id_ex_stall`, `ex_mem_stall`  out  1 each  stage register holds its value
- `if_id_flush`, `id_ex_flush`  out  1 each  stage register loads a NOP
- `mem_wb_bubble`  out  1  MEM/WB loads a NOP
- `halted`  out  1  FSM is in HALT
- `mem_err`  out  1  sticky flag, set on memory timeout
- `stall_cnt`, `flush_cnt`  out  32 each  performance counters; present only with `HAZARD_PERF_EN`

## Operation
- FSM states: RUN, MWAIT, HALT. Reset state: RUN. The FSM register, `halt_pend`, `mem_err` and the wait counter are cleared by reset.
- **freeze**: all of `pc_hold`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall` and `mem_wb_bubble` = 1; both flush outputs = 0.
- **RUN** (priority order):
  1. `mem_req & !mem_ready`: freeze; next state MWAIT; wait counter = 1.
  2. `br_taken`: `if_id_flush` = `id_ex_flush` = 1; no stalls. A branch overrides load-use.
  3. Load-use: `ex_memread & ex_rd != 0 & (ex_rd == id_rs1 | ex_rd == id_rs2)` gives `pc_hold` = `if_id_stall` = `id_ex_flush` = 1.
  4. `halt_req` with none of 1–3 active: next state HALT; the current cycle proceeds normally.
  5. Otherwise all outputs are 0.
- **MWAIT**:
  - Freeze while `!mem_ready`; the wait counter increments.
  - When `mem_ready` arrives: release this cycle (MEM/WB captures the result, `mem_wb_bubble` = 0, other outputs evaluated as in RUN items 2–3). Next state is HALT if `halt_pend`, else RUN.
  - If the counter reaches `MEM_TIMEOUT` without `mem_ready`: set `mem_err`, next state HALT.
  - `br_taken` and load-use are ignored while frozen.
- **HALT**:
  - Freeze and `halted` = 1.
  - `resume` leads to RUN on the next cycle, clears `halt_pend`, and clears `mem_err`.
  - `resume` is ignored if `halt_req` is still high.
- `halt_pend` is set when `halt_req` is seen in MWAIT, and cleared on entry to HALT.
- Reset mid-MWAIT or mid-HALT returns to RUN with all outputs 0 in the first cycle after reset.

## Timing
- All stall/flush outputs are combinational from registered state plus current inputs; zero-cycle latency.
- State changes at the edge following the triggering condition.
- Load-use produces exactly one bubble: the next cycle shows `ex_memread` = 0 for the bubble.
- `halted` rises one cycle after `halt_req` is accepted. It falls one cycle after `resume`.
- Wait counter width is `$clog2(MEM_TIMEOUT)+1`. It saturates and never wraps.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stall_cnt` increments in every cycle with `pc_hold` = 1.
  - `flush_cnt` increments in every cycle with `if_id_flush` = 1.
  - Both counters wrap at 2^32 and clear on reset.
- Not defined: the counter ports and their logic are absent.

## Structure
- Shared package `core_pkg`: FSM state enum (`HZ_RUN`, `HZ_MWAIT`, `HZ_HALT`), `REG_ZERO` (5'd0), `NOP_INSTR` (32'h00000013).
- One sub-module: `hazard_detect`, the combinational load-use comparator.

## Test plan
- Load `ex_rd`=5, `id_rs1`=5, `ex_memread`=1 in RUN → `pc_hold`=`if_id_stall`=`id_ex_flush`=1 for exactly 1 cycle. Same with `ex_rd`=0 → no stall.
- Load-use and `br_taken`=1 in the same cycle → both flush outputs = 1, `pc_hold`=0.
- `mem_req`=1 with `mem_ready` arriving after 3 cycles → freeze for 3 cycles, release in the ready cycle, state returns to RUN.
- `halt_req` during MWAIT, then `mem_ready` → `halted`=1 on the next cycle. `resume` pulse → RUN on the next cycle with outputs 0.
- `MEM_TIMEOUT`=4 and `mem_ready` never asserted → `mem_err`=1 and HALT after 4 MWAIT cycles. `resume` clears `mem_err`.
- `rstn`=0 asserted mid-HALT → next cycle shows RUN, `halted`=0, all outputs 0. With `HAZARD_PERF_EN` defined, counters read 0.
